// File: rtl/id_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : id_issue_buffer
//  Description : Decode-to-execute issue buffer. A small in-order FIFO of
//                decoded micro-ops with a RUN / MC_WAIT state machine that
//                inserts bubbles while a multi-cycle (mul/div) op executes.
//
//  Parameters  : DATA_W - width of one decoded micro-op
//                DEPTH  - number of buffered micro-ops (power of two, 2..16)
//                MC_W   - width of the multi-cycle latency field
//
//  Ports       : clk        - system clock, all state on rising edge
//                Rst        - synchronous active-high reset
//                hold       - freeze, no state changes while high
//                flush      - discard every buffered op (beats hold)
//                in_valid   - decode presents a micro-op
//                in_data    - decoded micro-op
//                in_mc      - op is multi-cycle
//                in_mc_lat  - execute cycles needed by a multi-cycle op
//                in_ready   - buffer accepts in_data this cycle
//                out_valid  - head op presented to execute (low = bubble)
//                out_data   - head micro-op, all-zero when out_valid is low
//                out_ready  - execute consumes the head this cycle
//                mc_done    - multiplier/divider finished early
//                count      - number of occupied entries
//                mc_busy    - state machine is in MC_WAIT
//
//  Options     : ID_ISSUE_BYPASS_EN - when defined, an op offered to an empty
//                buffer in RUN with out_ready high passes straight through
//                to out_data and dispatches in the same cycle. When not
//                defined there is no in_data -> out_data combinational path.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module id_issue_buffer #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int MC_W   = 6
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_mc,
    input  logic [MC_W-1:0]         in_mc_lat,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    input  logic                    mc_done,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    mc_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_PTR_W   = $clog2(DEPTH);
    localparam int                  c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);
    localparam logic [MC_W-1:0]     c_LAT_ONE = MC_W'(1);

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_MC_WAIT = 1'b1;

    // ------------------------------------------------------------------------
    // Storage (contents are never reset; only pointers/count carry validity)
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic               r_mem_mc   [DEPTH];
    logic [MC_W-1:0]    r_mem_lat  [DEPTH];

    // ------------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------------
    logic [0:0]         r_state,  w_state_next;
    logic [MC_W-1:0]    r_mc_cnt, w_mc_cnt_next;
    logic [c_PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
    logic [c_PTR_W-1:0] r_rd_ptr, w_rd_ptr_next;
    logic [c_CNT_W-1:0] r_count,  w_count_next;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic               w_live;
    logic               w_empty;
    logic               w_full;
    logic               w_run;
    logic               w_head_valid;
    logic               w_byp_valid;
    logic               w_out_valid;
    logic               w_dispatch;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_disp_mc;
    logic [MC_W-1:0]    w_disp_lat;

    // A cycle only "counts" when neither flush nor hold is active.
    assign w_live       = !hold && !flush;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_DEPTH);
    assign w_run        = (r_state == c_ST_RUN);
    assign w_head_valid = w_run && !w_empty;

`ifdef ID_ISSUE_BYPASS_EN
    // Pass-through only when it will actually dispatch this cycle, so the
    // op is never shown to execute without also being consumed.
    assign w_byp_valid  = w_run && w_empty && in_valid && out_ready && w_live;
    assign w_disp_mc    = w_byp_valid ? in_mc     : r_mem_mc[r_rd_ptr];
    assign w_disp_lat   = w_byp_valid ? in_mc_lat : r_mem_lat[r_rd_ptr];
`else
    assign w_byp_valid  = 1'b0;
    assign w_disp_mc    = r_mem_mc[r_rd_ptr];
    assign w_disp_lat   = r_mem_lat[r_rd_ptr];
`endif

    assign w_out_valid  = w_head_valid || w_byp_valid;
    assign w_dispatch   = w_out_valid && out_ready && w_live;

    // A full buffer can still take a new op when the head leaves this cycle.
    assign w_in_ready   = !w_full || w_dispatch;
    assign w_accept     = in_valid && w_in_ready && w_live;

    // Bypassed ops are dispatched directly and never touch the storage.
    assign w_pop        = w_dispatch && w_head_valid;
    assign w_push       = w_accept && !w_byp_valid;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state  <= c_ST_RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mc_cnt <= w_mc_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_mc_cnt_next = r_mc_cnt;
        if (flush) begin
            w_state_next  = c_ST_RUN;
            w_mc_cnt_next = '0;
        end else if (!hold) begin
            case (r_state)
                c_ST_RUN: begin
                    // Latency 0 or 1 is indistinguishable from a plain op.
                    if (w_dispatch && w_disp_mc && (w_disp_lat > c_LAT_ONE)) begin
                        w_state_next  = c_ST_MC_WAIT;
                        w_mc_cnt_next = w_disp_lat - c_LAT_ONE;
                    end
                end
                c_ST_MC_WAIT: begin
                    // Leave when this cycle's decrement reaches zero, or when
                    // the unit signals it finished early.
                    if (mc_done || (r_mc_cnt <= c_LAT_ONE)) begin
                        w_state_next  = c_ST_RUN;
                        w_mc_cnt_next = '0;
                    end else begin
                        w_mc_cnt_next = r_mc_cnt - c_LAT_ONE;
                    end
                end
                default: begin
                    w_state_next  = c_ST_RUN;
                    w_mc_cnt_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM / datapath: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid = w_out_valid;
        in_ready  = w_in_ready;
        count     = r_count;
        mc_busy   = (r_state == c_ST_MC_WAIT);
        // Execute must see an all-zero NOP whenever nothing is presented.
        out_data  = '0;
        if (w_head_valid) begin
            out_data = r_mem_data[r_rd_ptr];
        end
`ifdef ID_ISSUE_BYPASS_EN
        else if (w_byp_valid) begin
            out_data = in_data;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + c_CNT_ONE;
                2'b01:   w_count_next = r_count - c_CNT_ONE;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_mc[r_wr_ptr]   <= in_mc;
            r_mem_lat[r_wr_ptr]  <= in_mc_lat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_issue_buffer
//  Description : Self-checking bench for id_issue_buffer. Directed scenarios
//                followed by randomized traffic, all compared each cycle
//                against a queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_issue_buffer;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;
    localparam int MC_W   = 6;
`ifdef ID_ISSUE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   hold;
    logic                   flush;
    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic                   in_mc;
    logic [MC_W-1:0]        in_mc_lat;
    logic                   in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic                   out_ready;
    logic                   mc_done;
    logic [$clog2(DEPTH):0] count;
    logic                   mc_busy;

    always #5 clk = ~clk;

    id_issue_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MC_W   (MC_W)
    ) u_dut (
        .clk       (clk),
        .Rst       (rst),
        .hold      (hold),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_mc     (in_mc),
        .in_mc_lat (in_mc_lat),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .mc_done   (mc_done),
        .count     (count),
        .mc_busy   (mc_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a plain queue of ops plus a busy countdown.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [DATA_W-1:0] data;
        bit                mc;
        int                lat;
    } op_t;

    op_t         q[$];
    bit          m_busy = 1'b0;
    int          m_rem  = 0;
    bit          e_valid;
    bit          e_in_ready;
    logic [DATA_W-1:0] e_data;

    // Drive one cycle of inputs after the falling edge, then compare outputs.
    task automatic apply(input bit r, input bit h, input bit f, input bit iv,
                         input logic [DATA_W-1:0] d, input bit mc, input int lat,
                         input bit ordy, input bit done);
        bit live;
        @(negedge clk);
        rst       = r;
        hold      = h;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        in_mc     = mc;
        in_mc_lat = MC_W'(lat);
        out_ready = ordy;
        mc_done   = done;
        #1;
        live       = !h && !f;
        e_valid    = !m_busy && ((q.size() > 0) || (c_BYP && iv && ordy && live));
        e_data     = !e_valid ? '0 : ((q.size() > 0) ? q[0].data : d);
        e_in_ready = (q.size() < DEPTH) || (e_valid && ordy && live);
        check("out_valid", DATA_W'(out_valid), DATA_W'(e_valid));
        check("out_data",  out_data, e_data);
        check("in_ready",  DATA_W'(in_ready), DATA_W'(e_in_ready));
        check("count",     DATA_W'(count), DATA_W'(q.size()));
        check("mc_busy",   DATA_W'(mc_busy), DATA_W'(m_busy));
    endtask

    // Advance the model across the rising edge using the held inputs.
    task automatic tick();
        op_t op;
        bit  disp;
        bit  acc;
        bit  byp;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            m_busy = 1'b0;
            m_rem  = 0;
        end else if (!hold) begin
            disp = e_valid && out_ready;
            acc  = in_valid && e_in_ready;
            byp  = disp && (q.size() == 0);
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0 || mc_done) m_busy = 1'b0;
            end else if (disp) begin
                if (byp) begin
                    op.data = in_data;
                    op.mc   = in_mc;
                    op.lat  = int'(in_mc_lat);
                end else begin
                    op = q[0];
                end
                if (op.mc && op.lat > 1) begin
                    m_busy = 1'b1;
                    m_rem  = op.lat - 1;
                end
            end
            if (disp && !byp) void'(q.pop_front());
            if (acc && !byp) begin
                op.data = in_data;
                op.mc   = in_mc;
                op.lat  = int'(in_mc_lat);
                q.push_back(op);
            end
        end
    endtask

    task automatic step(input bit h, input bit iv, input logic [DATA_W-1:0] d,
                        input bit mc, input int lat, input bit ordy);
        apply(1'b0, h, 1'b0, iv, d, mc, lat, ordy, 1'b0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_mc = 1'b0; in_mc_lat = '0; out_ready = 1'b0; mc_done = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        apply(0, 0, 0, 0, '0, 0, 0, 0, 0);
        check("rst_count", DATA_W'(count), 0);
        check("rst_in_ready", DATA_W'(in_ready), 1);
        tick();

        // Fill to DEPTH with execute stalled; fifth op must be refused
        for (int k = 1; k <= 4; k++) step(0, 1, DATA_W'(k), 0, 0, 0);
        apply(0, 0, 0, 1, DATA_W'(5), 0, 0, 0, 0);
        check("full_count", DATA_W'(count), 4);
        check("full_in_ready", DATA_W'(in_ready), 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
            check("drain_order", out_data, DATA_W'(k));
            tick();
        end

        // Full buffer: accept and dispatch together
        for (int k = 0; k < 4; k++) step(0, 1, DATA_W'(8'h11 + k), 0, 0, 0);
        apply(0, 0, 0, 1, DATA_W'(8'h15), 0, 0, 1, 0);
        check("full_swap_ready", DATA_W'(in_ready), 1);
        tick();
        apply(0, 0, 0, 0, '0, 0, 0, 0, 0);
        check("full_swap_count", DATA_W'(count), 4);
        check("full_swap_head", out_data, DATA_W'(8'h12));
        tick();
        repeat (4) step(0, 0, '0, 0, 0, 1);

        // Multi-cycle op, latency 5, runs to completion
        step(0, 1, DATA_W'(8'h0A), 1, 5, 0);
        step(0, 1, DATA_W'(8'h0B), 0, 0, 0);
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("mc_head", out_data, DATA_W'(8'h0A));
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
            check("mc_wait_busy", DATA_W'(mc_busy), 1);
            check("mc_wait_bubble", DATA_W'(out_valid), 0);
            tick();
        end
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("mc_exit_valid", DATA_W'(out_valid), 1);
        check("mc_exit_data", out_data, DATA_W'(8'h0B));
        tick();

        // Same again with early completion in the second wait cycle
        step(0, 1, DATA_W'(8'h0C), 1, 5, 0);
        step(0, 1, DATA_W'(8'h0D), 0, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 0, '0, 0, 0, 1, 1);
        check("mc_done_busy", DATA_W'(mc_busy), 1);
        tick();
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("mc_done_exit", out_data, DATA_W'(8'h0D));
        tick();

        // Flush while in MC_WAIT with three ops queued
        step(0, 1, DATA_W'(8'h31), 1, 10, 0);
        for (int k = 0; k < 3; k++) step(0, 1, DATA_W'(8'h32 + k), 0, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("pre_flush_count", DATA_W'(count), 3);
        tick();
        apply(0, 0, 1, 1, DATA_W'(8'h99), 0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("flush_count", DATA_W'(count), 0);
        check("flush_busy", DATA_W'(mc_busy), 0);
        check("flush_data", out_data, '0);
        tick();

        // Hold freezes a waiting multi-cycle op; reset during hold clears all
        step(0, 1, DATA_W'(8'h41), 1, 6, 0);
        step(0, 1, DATA_W'(8'h42), 0, 0, 0);
        step(0, 1, DATA_W'(8'h43), 0, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 0, 1, DATA_W'(8'h4F), 0, 0, 1, 0);
            check("hold_count", DATA_W'(count), 2);
            tick();
        end
        repeat (2) step(0, 0, '0, 0, 0, 0);
        apply(1, 1, 0, 1, DATA_W'(8'h4F), 0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("hold_rst_count", DATA_W'(count), 0);
        check("hold_rst_busy", DATA_W'(mc_busy), 0);
        tick();

        // Empty buffer latency (zero with bypass, one without)
        apply(0, 0, 0, 1, DATA_W'(8'hA5), 0, 0, 1, 0);
        check("lat_valid0", DATA_W'(out_valid), DATA_W'(c_BYP));
        check("lat_data0", out_data, c_BYP ? DATA_W'(8'hA5) : '0);
        tick();
        apply(0, 0, 0, 0, '0, 0, 0, 1, 0);
        check("lat_valid1", DATA_W'(out_valid), DATA_W'(!c_BYP));
        check("lat_data1", out_data, c_BYP ? '0 : DATA_W'(8'hA5));
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1,
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, 8)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_issue_buffer.md
ID_ISSUE_BUFFER -- requirements
Module: id_issue_buffer

Interface
REQ-001 Parameter DATA_W, default 128, width of one decoded micro-op (control fields, rs/rd, operands, imm, PC).
REQ-002 Parameter DEPTH, default 4, number of buffered micro-ops; SHALL be a power of two, 2..16.
REQ-003 Parameter MC_W, default 6, width of multi-cycle latency field.
REQ-004 clk  in  1  system clock; one clock; all state updates on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 hold  in  1  freeze (dbg or mem_hold); no state changes while high.
REQ-007 flush  in  1  branch taken / trap / trap return; discard all buffered ops.
REQ-008 in_valid  in  1  decode presents a micro-op.
REQ-009 in_data  in  DATA_W  decoded micro-op.
REQ-010 in_mc  in  1  op is multi-cycle (mul/div).
REQ-011 in_mc_lat  in  MC_W  execute cycles required by a multi-cycle op.
REQ-012 in_ready  out  1  buffer accepts in_data this cycle.
REQ-013 out_valid  out  1  head op presented to execute; low = bubble.
REQ-014 out_data  out  DATA_W  head micro-op; all-zero when out_valid low.
REQ-015 out_ready  in  1  execute consumes head this cycle.
REQ-016 mc_done  in  1  multiplier/divider early completion.
REQ-017 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-018 mc_busy  out  1  FSM in MC_WAIT.

Function
REQ-019 Accept SHALL occur on in_valid & in_ready & !hold & !flush; dispatch on out_valid & out_ready & !hold & !flush.
REQ-020 in_ready SHALL equal (count < DEPTH) | dispatch-this-cycle; accept into a full buffer with simultaneous dispatch SHALL succeed.
REQ-021 Entries SHALL leave in acceptance order; pointers wrap modulo DEPTH.
REQ-022 Simultaneous accept and dispatch SHALL leave count unchanged.
REQ-023 FSM states RUN, MC_WAIT.
REQ-024 RUN -> MC_WAIT on dispatch of an entry with mc=1 and lat>1; counter loads lat-1.
REQ-025 In MC_WAIT out_valid SHALL be 0, counter decrements each non-hold cycle; exit to RUN when counter reaches 0 or mc_done high.
REQ-026 mc flag with lat of 0 or 1 SHALL behave as a single-cycle op (stay RUN).
REQ-027 Latency: op accepted into empty buffer in RUN SHALL appear on out_valid the following cycle.
REQ-028 flush SHALL, on the same edge, set count to 0, pointers to 0, FSM to RUN, counter to 0; in_data presented in the flush cycle is dropped.
REQ-029 hold SHALL take priority over accept, dispatch and counter decrement; flush SHALL take priority over hold.
REQ-030 out_data SHALL be zero whenever out_valid is low (execute sees a NOP bubble).

Reset
REQ-031 On Rst: count=0, pointers=0, FSM=RUN, counter=0, out_valid=0, out_data=0, mc_busy=0, in_ready=1 from the next cycle.
REQ-032 Rst SHALL dominate flush and hold; reset mid-MC_WAIT returns to RUN with the buffer empty.
REQ-033 Storage contents need not reset; only valid/pointer state does.

Configuration
REQ-034 Macro ID_ISSUE_BYPASS_EN: when defined, an op offered while buffer empty, FSM RUN and out_ready high SHALL pass combinationally in_data -> out_data and dispatch in the same cycle without being stored (zero latency).
REQ-035 Without ID_ISSUE_BYPASS_EN, latency SHALL be exactly one cycle per REQ-027 and no in->out combinational path exists.

Verification
REQ-036 DEPTH=4, push 5 ops with out_ready=0 -> in_ready low after 4th, count=4, 5th not accepted; release out_ready -> ops emerge in order 1..4.
REQ-037 Full buffer, in_valid=1 and out_ready=1 same cycle -> accept and dispatch both occur, count stays 4.
REQ-038 Dispatch mc op lat=5 -> mc_busy high 4 cycles, out_valid 0 during them, next op dispatched in 5th cycle; repeat with mc_done at cycle 2 -> exit after 2.
REQ-039 Buffer with 3 ops, MC_WAIT active, assert flush -> next cycle count=0, mc_busy=0, out_valid=0, out_data=0.
REQ-040 hold high 3 cycles with in_valid and out_ready high -> count, pointers, counter unchanged; Rst asserted during hold -> state reset.
REQ-041 With ID_ISSUE_BYPASS_EN, empty buffer, in_valid=1, out_ready=1, in_data=0xA5 -> out_valid=1, out_data=0xA5 same cycle, count stays 0; without macro -> appears next cycle.
